fa_bist_checker: RTL
====================

# fa_bist_checker

Synthesizable self-checking driver for the single-bit `full_adder`. It sequences all 8 input combinations into a full adder under test and samples its sum and carry. It compares them against a built-in golden model and reports a pass/fail verdict plus error diagnostics. It sits beside a `full_adder` instance as the on-chip counterpart to the stimulus bench: the driving and observing end of the `a/b/cin -> s/c` interface.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: number of cycles each vector is held before sampling. Legal range is 1..15.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse that begins a run. Honoured only in IDLE or DONE.
- `dut_a`, `dut_b`, `dut_cin`  out  1 each  registered stimulus to the adder under test.
- `dut_s`, `dut_c`  in  1 each  sum and carry returned by the adder under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high in DONE, held until the next `start` or reset.
- `pass`  out  1  valid when `done`=1. Equals 1 iff `err_count`==0.
- `err_count`  out  4  number of mismatching vectors in the last run, range 0..8.
- `first_fail_valid`  out  1  at least one mismatch has been seen in this run.
- `first_fail_vec`  out  3  vector index of the first mismatch. Meaningful only when `first_fail_valid`=1.

## Operation
- States:
  - IDLE
  - SETTLE (hold the current vector)
  - CHECK (sample and compare)
  - DONE
- Vector index `vec[2:0]` maps to the adder inputs as `dut_a`=vec[2], `dut_b`=vec[1], `dut_cin`=vec[0].
- Expected results:
  - exp_s = a^b^cin.
  - exp_c = (a&b)|(a&cin)|(b&cin).
- IDLE or DONE, with `start`=1:
  - Go to SETTLE.
  - Set vec=0 and the settle counter to SETTLE_CYCLES-1.
  - Clear `err_count`, `first_fail_valid`, `first_fail_vec`, `done` and `pass`.
- SETTLE: decrement the settle counter each cycle. When the counter is 0, go to CHECK.
- CHECK, one cycle:
  - Compare `{dut_s,dut_c}` with the expected pair.
  - On mismatch, increment `err_count`. If `first_fail_valid`=0, also set it and load `first_fail_vec`=vec.
  - If vec==7, go to DONE. Otherwise increment vec, reload the settle counter and go to SETTLE.
- DONE:
  - `done`=1 and `pass`=(err_count==0). Diagnostics are held.
  - `dut_*` keep the last vector (7).
- `busy`=1 in SETTLE and CHECK. `start` is ignored while `busy`=1.
- The index never wraps: exactly 8 checks per run, each vector checked once, in order 0..7.

## Timing
- Reset value of every output is 0: `dut_a`, `dut_b`, `dut_cin`, `busy`, `done`, `pass`, `err_count`, `first_fail_valid`, `first_fail_vec`. State resets to IDLE.
- Reset asserted mid-run aborts immediately and asynchronously to the reset values. No partial verdict is retained.
- Latency: with `start` high at edge N, `busy`=1 and vector 0 appear after edge N+1.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- `done` rises after edge N+1+8·(SETTLE_CYCLES+1). With the default this is N+17.
- `dut_s`/`dut_c` are sampled at the CHECK-cycle edge, so they are stable for at least SETTLE_CYCLES full cycles before sampling.
- Simultaneous `start` and entry into DONE: `start` is ignored, because the block is still busy in that cycle.

## Structure
- Package `fa_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - `VEC_W`=3 and `NUM_VEC`=8;
  - `CNT_W`=4.
- One sub-module, `fa_golden`: a combinational reference model taking `a, b, cin` and producing `exp_s, exp_c`. It is written behaviourally, independent of any structural `full_adder`.
- Top level contains the FSM, the vec/settle counters and the diagnostic registers.

## Test plan
- Correct `full_adder` attached, default parameter, `start` pulsed at cycle 2:
  - `busy` is high cycles 3..18.
  - `done`=1 and `pass`=1 from cycle 19.
  - `err_count`=0 and `first_fail_valid`=0.
- DUT with `s` stuck-at-0: mismatches occur at vec 1, 2, 4, 7, so `err_count`=4, `first_fail_vec`=1 and `pass`=0.
- DUT with `c` inverted: all 8 vectors fail, so `err_count`=8, `first_fail_vec`=0 and `pass`=0.
- `SETTLE_CYCLES`=3:
  - Each vector is held for 4 cycles.
  - `done` rises 33 cycles after the `start` edge.
  - `dut_a/b/cin` step through 000..111 in order.
- `start` re-pulsed mid-run at vec 3: it is ignored, and the run completes with the original timing. A second `start` issued from DONE clears diagnostics and reruns.
- `rst_n` pulled low asynchronously between clock edges while vec=5: all outputs go to 0 immediately and the state returns to IDLE. After release, `done` stays 0 until a new `start`.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// Shared types and sizes for the full-adder BIST checker.
// Imported by the checker top and its golden model.
package fa_bist_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/fa_golden.sv
// Behavioural reference for one full-adder bit.
// Independent of any structural full_adder netlist.
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic exp_s,
  output logic exp_c
);

  always_comb begin
    exp_s = a ^ b ^ cin;
    exp_c = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/fa_bist_checker.sv
// Drives all 8 vectors into an external full adder and
// checks sum/carry against fa_golden, keeping diagnostics.
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_s,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec
);

  import fa_bist_pkg::*;

  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST =
    VEC_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffvec_q, ffvec_d;
  logic             exp_s, exp_c;
  logic             mis;

  fa_golden u_golden (
    .a     (vec_q[2]),
    .b     (vec_q[1]),
    .cin   (vec_q[0]),
    .exp_s (exp_s),
    .exp_c (exp_c)
  );

  assign mis = {dut_s, dut_c} != {exp_s, exp_c};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = RELOAD;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else cnt_d = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (mis) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        // index stops at the last vector; no wrap
        if (vec_q == LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = RELOAD;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign dut_a            = vec_q[2];
  assign dut_b            = vec_q[1];
  assign dut_cin          = vec_q[0];
  assign busy             = (state_q == S_SETTLE) ||
                            (state_q == S_CHECK);
  assign done             = state_q == S_DONE;
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
